// File: rtl/pc_fetch_sequencer_pkg.sv
// rtl/pc_fetch_sequencer_pkg.sv - shared state encoding and defaults for the fetch sequencer
package pc_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEFAULT  = 4;

endpackage

// File: rtl/pc_fetch_sequencer_adder.sv
// rtl/pc_fetch_sequencer_adder.sv - modulo-2^WIDTH adder used for PC increments
module Adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] Adder_IN1,
    input  logic [WIDTH-1:0] Adder_IN2,
    output logic [WIDTH-1:0] Adder_OUT
);

    // Carry out is dropped on purpose: PC arithmetic wraps silently.
    assign Adder_OUT = Adder_IN1 + Adder_IN2;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - program counter owner and instruction fetch sequencer
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(RESET_PC_DEFAULT),
    parameter int unsigned       PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Stall,
    input  logic             Jump,
    input  logic [WIDTH-1:0] Jump_Target,
    input  logic             Branch_Taken,
    input  logic [WIDTH-1:0] Branch_Target,
    output logic             IMem_Req,
    output logic [WIDTH-1:0] IMem_Addr,
    input  logic             IMem_Ack,
    input  logic [WIDTH-1:0] IMem_RData,
    output logic             Fetch_Valid,
    output logic [WIDTH-1:0] Fetch_Instr,
    output logic [WIDTH-1:0] Fetch_PC,
    output logic [WIDTH-1:0] Fetch_PC_Plus4,
    output logic             Fault
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             req_q, req_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] fpc_q, fpc_d;
    logic             fault_q, fault_d;

    logic             redir;
    logic [WIDTH-1:0] redir_tgt;
    logic             redir_bad;
    logic [WIDTH-1:0] pc_next_seq;

    Adder #(.WIDTH(WIDTH)) u_pc_adder (
        .Adder_IN1 (pc_q),
        .Adder_IN2 (STEP),
        .Adder_OUT (pc_next_seq)
    );

    Adder #(.WIDTH(WIDTH)) u_link_adder (
        .Adder_IN1 (fpc_q),
        .Adder_IN2 (STEP),
        .Adder_OUT (Fetch_PC_Plus4)
    );

    // Jump outranks a simultaneous branch; a misaligned winner is a fault.
    always_comb begin
        redir     = Jump | Branch_Taken;
        redir_tgt = Jump ? Jump_Target : Branch_Target;
        redir_bad = redir && (redir_tgt[1:0] != 2'b00);
    end

    // Next-state and next-output logic for the fetch FSM.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pending_d  = pending_q;
        pend_tgt_d = pend_tgt_q;
        req_d      = req_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        fpc_d      = fpc_q;
        fault_d    = fault_q;

        unique case (state_q)
            S_BOOT: begin
                // Redirects are ignored until the first request goes out.
                state_d = S_REQ;
                req_d   = 1'b1;
            end
            S_REQ: begin
                if (redir_bad) begin
                    state_d = S_FAULT;
                    req_d   = 1'b0;
                    valid_d = 1'b0;
                    fault_d = 1'b1;
                end else if (IMem_Ack) begin
                    if (redir || pending_q) begin
                        // Returned word belongs to the old stream; refetch at target.
                        pc_d      = redir ? redir_tgt : pend_tgt_q;
                        pending_d = 1'b0;
                    end else begin
                        instr_d = IMem_RData;
                        fpc_d   = pc_q;
                        valid_d = 1'b1;
                        req_d   = 1'b0;
                        state_d = S_VALID;
                    end
                end else if (redir) begin
                    // Address must stay stable, so remember the redirect until Ack.
                    pending_d  = 1'b1;
                    pend_tgt_d = redir_tgt;
                end
            end
            S_VALID: begin
                if (redir_bad) begin
                    state_d = S_FAULT;
                    valid_d = 1'b0;
                    fault_d = 1'b1;
                end else if (redir) begin
                    valid_d = 1'b0;
                    pc_d    = redir_tgt;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end else if (!Stall) begin
                    valid_d = 1'b0;
                    pc_d    = pc_next_seq;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_FAULT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                fault_d = 1'b1;
            end
            default: state_d = S_BOOT;
        endcase
    end

    // State and registered outputs; reset abandons any in-flight request.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            pending_q  <= 1'b0;
            pend_tgt_q <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            fpc_q      <= RESET_PC;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            pend_tgt_q <= pend_tgt_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            fpc_q      <= fpc_d;
            fault_q    <= fault_d;
        end
    end

    assign IMem_Req    = req_q;
    assign IMem_Addr   = pc_q;
    assign Fetch_Valid = valid_q;
    assign Fetch_Instr = instr_q;
    assign Fetch_PC    = fpc_q;
    assign Fault       = fault_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - directed self-checking bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Stall;
    logic        Jump;
    logic [31:0] Jump_Target;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ack;
    logic [31:0] IMem_RData;
    logic        Fetch_Valid;
    logic [31:0] Fetch_Instr;
    logic [31:0] Fetch_PC;
    logic [31:0] Fetch_PC_Plus4;
    logic        Fault;

    int checks = 0;
    int errors = 0;

    pc_fetch_sequencer dut (
        .CLK            (CLK),
        .RST            (RST),
        .Stall          (Stall),
        .Jump           (Jump),
        .Jump_Target    (Jump_Target),
        .Branch_Taken   (Branch_Taken),
        .Branch_Target  (Branch_Target),
        .IMem_Req       (IMem_Req),
        .IMem_Addr      (IMem_Addr),
        .IMem_Ack       (IMem_Ack),
        .IMem_RData     (IMem_RData),
        .Fetch_Valid    (Fetch_Valid),
        .Fetch_Instr    (Fetch_Instr),
        .Fetch_PC       (Fetch_PC),
        .Fetch_PC_Plus4 (Fetch_PC_Plus4),
        .Fault          (Fault)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; Stall = 1'b0; Jump = 1'b0; Branch_Taken = 1'b0;
        Jump_Target = '0; Branch_Target = '0; IMem_Ack = 1'b0; IMem_RData = '0;
        step(); step();
        checks++; if (IMem_Req !== 1'b0) begin $display("FAIL reset_req got %b exp 0", IMem_Req); errors++; end
        checks++; if (Fetch_Valid !== 1'b0) begin $display("FAIL reset_valid got %b exp 0", Fetch_Valid); errors++; end
        checks++; if (Fault !== 1'b0) begin $display("FAIL reset_fault got %b exp 0", Fault); errors++; end
        checks++; if (Fetch_PC !== 32'h0) begin $display("FAIL reset_fpc got %h exp 0", Fetch_PC); errors++; end
        checks++; if (Fetch_Instr !== 32'h0) begin $display("FAIL reset_instr got %h exp 0", Fetch_Instr); errors++; end
        RST = 1'b0;
    endtask

    task automatic test_sequential();
        step();
        checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0) begin $display("FAIL seq_req0 got req=%b addr=%h exp 1/0", IMem_Req, IMem_Addr); errors++; end
        IMem_Ack = 1'b1; IMem_RData = 32'h2000_0001;
        step();
        IMem_Ack = 1'b0;
        checks++; if (Fetch_Valid !== 1'b1 || Fetch_PC !== 32'h0 || Fetch_Instr !== 32'h2000_0001) begin $display("FAIL seq_valid0 got v=%b pc=%h i=%h exp 1/0/20000001", Fetch_Valid, Fetch_PC, Fetch_Instr); errors++; end
        checks++; if (Fetch_PC_Plus4 !== 32'h4 || IMem_Req !== 1'b0) begin $display("FAIL seq_plus4_0 got p4=%h req=%b exp 4/0", Fetch_PC_Plus4, IMem_Req); errors++; end
        step();
        checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h4 || Fetch_Valid !== 1'b0) begin $display("FAIL seq_req4 got req=%b addr=%h v=%b exp 1/4/0", IMem_Req, IMem_Addr, Fetch_Valid); errors++; end
        IMem_Ack = 1'b1; IMem_RData = 32'h2000_0001;
        step();
        IMem_Ack = 1'b0;
        checks++; if (Fetch_Valid !== 1'b1 || Fetch_PC !== 32'h4 || Fetch_PC_Plus4 !== 32'h8) begin $display("FAIL seq_valid4 got v=%b pc=%h p4=%h exp 1/4/8", Fetch_Valid, Fetch_PC, Fetch_PC_Plus4); errors++; end
    endtask

    task automatic test_stall();
        Stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (Fetch_Valid !== 1'b1 || Fetch_PC !== 32'h4 || Fetch_Instr !== 32'h2000_0001 || IMem_Req !== 1'b0) begin $display("FAIL stall_hold%0d got v=%b pc=%h i=%h req=%b exp 1/4/20000001/0", i, Fetch_Valid, Fetch_PC, Fetch_Instr, IMem_Req); errors++; end
        end
        Stall = 1'b0;
        step();
        checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h8 || Fetch_Valid !== 1'b0) begin $display("FAIL stall_release got req=%b addr=%h v=%b exp 1/8/0", IMem_Req, IMem_Addr, Fetch_Valid); errors++; end
    endtask

    task automatic test_branch_pending();
        Branch_Taken = 1'b1; Branch_Target = 32'h40;
        step();
        Branch_Taken = 1'b0; Branch_Target = 32'h0;
        step(); step();
        checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h8 || Fetch_Valid !== 1'b0) begin $display("FAIL pend_wait got req=%b addr=%h v=%b exp 1/8/0", IMem_Req, IMem_Addr, Fetch_Valid); errors++; end
        IMem_Ack = 1'b1; IMem_RData = 32'hDEAD_BEEF;
        step();
        IMem_Ack = 1'b0;
        checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h40 || Fetch_Valid !== 1'b0) begin $display("FAIL pend_discard got req=%b addr=%h v=%b exp 1/40/0", IMem_Req, IMem_Addr, Fetch_Valid); errors++; end
        IMem_Ack = 1'b1; IMem_RData = 32'h1111_2222;
        step();
        IMem_Ack = 1'b0;
        checks++; if (Fetch_Valid !== 1'b1 || Fetch_PC !== 32'h40 || Fetch_Instr !== 32'h1111_2222) begin $display("FAIL pend_fetch got v=%b pc=%h i=%h exp 1/40/11112222", Fetch_Valid, Fetch_PC, Fetch_Instr); errors++; end
    endtask

    task automatic test_jump_priority();
        Jump = 1'b1; Jump_Target = 32'h100;
        Branch_Taken = 1'b1; Branch_Target = 32'h200;
        step();
        Jump = 1'b0; Branch_Taken = 1'b0;
        checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h100 || Fetch_Valid !== 1'b0) begin $display("FAIL jump_prio got req=%b addr=%h v=%b exp 1/100/0", IMem_Req, IMem_Addr, Fetch_Valid); errors++; end
        IMem_Ack = 1'b1; IMem_RData = 32'h3333_4444;
        step();
        IMem_Ack = 1'b0;
        checks++; if (Fetch_Valid !== 1'b1 || Fetch_PC !== 32'h100 || Fetch_PC_Plus4 !== 32'h104) begin $display("FAIL jump_fetch got v=%b pc=%h p4=%h exp 1/100/104", Fetch_Valid, Fetch_PC, Fetch_PC_Plus4); errors++; end
    endtask

    task automatic test_fault();
        Jump = 1'b1; Jump_Target = 32'h102;
        step();
        Jump = 1'b0;
        checks++; if (Fault !== 1'b1 || IMem_Req !== 1'b0 || Fetch_Valid !== 1'b0) begin $display("FAIL fault_set got f=%b req=%b v=%b exp 1/0/0", Fault, IMem_Req, Fetch_Valid); errors++; end
        step(); step();
        checks++; if (Fault !== 1'b1 || IMem_Req !== 1'b0) begin $display("FAIL fault_sticky got f=%b req=%b exp 1/0", Fault, IMem_Req); errors++; end
        RST = 1'b1;
        #1;
        checks++; if (Fault !== 1'b0) begin $display("FAIL fault_clear got %b exp 0", Fault); errors++; end
        step();
        RST = 1'b0;
        step();
        checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0) begin $display("FAIL fault_resume got req=%b addr=%h exp 1/0", IMem_Req, IMem_Addr); errors++; end
    endtask

    task automatic test_wrap_and_async();
        Jump = 1'b1; Jump_Target = 32'hFFFF_FFFC;
        step();
        Jump = 1'b0;
        IMem_Ack = 1'b1; IMem_RData = 32'h5555_6666;
        step();
        checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'hFFFF_FFFC) begin $display("FAIL wrap_req got req=%b addr=%h exp 1/fffffffc", IMem_Req, IMem_Addr); errors++; end
        step();
        IMem_Ack = 1'b0;
        checks++; if (Fetch_Valid !== 1'b1 || Fetch_PC !== 32'hFFFF_FFFC || Fetch_PC_Plus4 !== 32'h0) begin $display("FAIL wrap_valid got v=%b pc=%h p4=%h exp 1/fffffffc/0", Fetch_Valid, Fetch_PC, Fetch_PC_Plus4); errors++; end
        step();
        checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0 || Fault !== 1'b0) begin $display("FAIL wrap_next got req=%b addr=%h f=%b exp 1/0/0", IMem_Req, IMem_Addr, Fault); errors++; end
        #2;
        RST = 1'b1;
        #1;
        checks++; if (IMem_Req !== 1'b0) begin $display("FAIL async_rst_req got %b exp 0", IMem_Req); errors++; end
        step();
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_pending();
        test_jump_priority();
        test_fault();
        test_wrap_and_async();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the MIPS core.
- Issues one request at a time to instruction memory using a req/ack handshake, and presents the fetched instruction to decode with a valid/stall handshake.
- Applies jump and branch redirects and advances the PC through the existing Adder block.

Parameters:
- WIDTH, 32, PC, target, address and instruction width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- PC_STEP, 4, sequential PC increment.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- Stall  in  1  decode not ready; Fetch_Valid & ~Stall means the instruction is consumed.
- Jump  in  1  one-cycle jump redirect pulse.
- Jump_Target  in  WIDTH  jump destination, sampled when Jump=1.
- Branch_Taken  in  1  one-cycle branch redirect pulse.
- Branch_Target  in  WIDTH  branch destination, sampled when Branch_Taken=1.
- IMem_Req  out  1  fetch request; held high until IMem_Ack.
- IMem_Addr  out  WIDTH  fetch address; equals PC; stable while IMem_Req=1.
- IMem_Ack  in  1  one-cycle completion strobe; IMem_RData valid in the same cycle.
- IMem_RData  in  WIDTH  instruction word.
- Fetch_Valid  out  1  Fetch_Instr and Fetch_PC are valid.
- Fetch_Instr  out  WIDTH  registered instruction.
- Fetch_PC  out  WIDTH  address of Fetch_Instr.
- Fetch_PC_Plus4  out  WIDTH  Fetch_PC + PC_STEP, for link and branch base.
- Fault  out  1  sticky flag for a misaligned redirect target.

Behaviour:
- Reset (async, any state): state=S_BOOT, PC=RESET_PC, pending=0, IMem_Req=0, Fetch_Valid=0, Fetch_Instr=0, Fetch_PC=RESET_PC, Fault=0. Any outstanding memory transaction is abandoned; memory must tolerate this.
- Redirect select: Jump has priority over Branch_Taken; call the result redir/redir_tgt. A target with tgt[1:0]!=0 goes to S_FAULT at the next edge and overrides everything else.
- S_BOOT: IMem_Req=0; go to S_REQ at the first edge after RST deasserts.
- S_REQ: IMem_Req=1, IMem_Addr=PC.
  - redir without Ack: pending=1, pend_tgt=redir_tgt (newest redirect overwrites). Stay.
  - Ack with redir or pending: discard data, PC=redir_tgt if redir else pend_tgt, clear pending, stay in S_REQ. The next cycle issues a new request at the new PC.
  - Ack, no redirect: Fetch_Instr=IMem_RData, Fetch_PC=PC, Fetch_Valid=1, go to S_VALID.
- S_VALID: IMem_Req=0, Fetch_Valid=1.
  - redir (wins over consume): Fetch_Valid=0, PC=redir_tgt, go to S_REQ. The redirect flushes the held instruction even if Stall=0.
  - ~Stall: consumed; Fetch_Valid=0, PC=PC+PC_STEP (Adder output), go to S_REQ.
  - Stall: hold all outputs and PC.
- S_FAULT: Fault=1, IMem_Req=0, Fetch_Valid=0; exit only by RST.
- Latency: minimum 2 cycles per instruction (request cycle with Ack, then valid cycle). First IMem_Req rises 1 cycle after reset release.
- Arithmetic: PC+PC_STEP is modulo 2^WIDTH; 32'hFFFF_FFFC wraps to 0 with no flag.
- Redirects arriving in S_BOOT are ignored.

Decomposition:
- Shared package holds: state encoding (S_BOOT=2'd0, S_REQ=2'd1, S_VALID=2'd2, S_FAULT=2'd3), RESET_PC default, PC_STEP default.
- Sub-module: instantiate the existing Adder (WIDTH) twice.
  - Adder_IN1=PC, Adder_IN2=PC_STEP, giving the next sequential PC.
  - Adder_IN1=Fetch_PC, Adder_IN2=PC_STEP, driving Fetch_PC_Plus4.
- Everything else is one FSM plus registers in this module.

Test Plan:
- Reset release, memory acks on the first request cycle with 0x2000_0001, Stall=0: IMem_Addr=0x0 then 0x4. Fetch_Valid is high every other cycle with Fetch_PC=0x0/0x4. Fetch_PC_Plus4=0x4/0x8.
- Stall=1 for 5 cycles during S_VALID: Fetch_Valid, Fetch_Instr and Fetch_PC are unchanged, IMem_Req=0. After Stall drops, the next IMem_Addr is Fetch_PC+4.
- Jump=1 (target 0x100) and Branch_Taken=1 (target 0x200) in the same cycle during S_VALID: next IMem_Addr=0x100, and the held instruction is never consumed.
- Branch_Taken (target 0x40) while the request at 0x8 waits 3 cycles for Ack: the 0x8 data is discarded, Fetch_Valid stays 0, and the next request is at 0x40.
- Jump_Target=0x102: Fault=1 from the next edge, IMem_Req=0 thereafter. RST clears Fault, and fetch resumes at RESET_PC.
- PC at 0xFFFF_FFFC is consumed: next IMem_Addr=0x0. An async RST pulse mid-request drops IMem_Req immediately (before the next edge).
